idct_coeff_block_writer: RTL and testbench

- Producer end of the pre-IDCT coefficient region in SRAM.
- Accepts a stream of 16-bit coefficients, one 8x8 block of 64 at a time, into a ping-pong buffer.
- Writes each block into SRAM at the pre-IDCT block layout that the IDCT fetch stage reads back: Y blocks, then U blocks, then V blocks, one 16-bit word per coefficient.
- Sits between the lossless/dequantisation decoder and the SRAM arbiter mux.

---
 rtl/idct_coeff_block_writer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_idct_coeff_block_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_coeff_block_writer.sv
// -----------------------------------------------------------------------------
// idct_coeff_block_writer
//
// Producer end of the pre-IDCT coefficient region in SRAM. Coefficients arrive
// one 8x8 block (64 words) at a time into a two-bank ping-pong buffer; a drain
// FSM writes each full bank to SRAM at the block layout the IDCT fetch stage
// reads back (all Y blocks, then U, then V, one 16-bit word per coefficient).
//
// Build option: define ZIGZAG_SCAN_EN when the incoming coefficients are in
// JPEG zigzag order; they are then stored at their raster position. Without
// it the input is taken to be raster order already.
//
// Ports:
//   Clock           - system clock, rising edge
//   Resetn          - asynchronous active-low reset
//   Enable          - start pulse, only honoured while idle
//   coeff_valid     - coefficient present on coeff_data
//   coeff_data      - signed 16-bit coefficient
//   coeff_ready     - coefficient accepted this cycle when valid is also high
//   SRAM_address    - registered write address
//   SRAM_write_data - registered write data
//   SRAM_we_n       - registered active-low write enable
//   block_written   - one-cycle pulse after the 64th word of a block
//   done            - frame complete, held until the next accepted Enable
// -----------------------------------------------------------------------------
module idct_coeff_block_writer #(
    parameter logic [17:0] PRE_IDCT_BASE = 18'd76800,
    parameter int unsigned Y_BLOCKS_X    = 40,
    parameter int unsigned UV_BLOCKS_X   = 20,
    parameter int unsigned BLOCKS_Y      = 30
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic        coeff_valid,
    input  logic [15:0] coeff_data,
    output logic        coeff_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        block_written,
    output logic        done
);

    localparam logic [17:0] U_BASE       = PRE_IDCT_BASE + 18'(Y_BLOCKS_X * BLOCKS_Y * 64);
    localparam logic [17:0] V_BASE       = U_BASE + 18'(UV_BLOCKS_X * BLOCKS_Y * 64);
    localparam int unsigned TOTAL_BLOCKS = (Y_BLOCKS_X + 2 * UV_BLOCKS_X) * BLOCKS_Y;

    typedef enum logic [2:0] {StIdle, StWait, StWrite, StNext, StDone} state_e;
    typedef enum logic [1:0] {PlaneY, PlaneU, PlaneV} plane_e;

    state_e      state_q, state_d;
    plane_e      plane_q, plane_d;
    logic        running_q, running_d;
    logic [1:0]  full_q, full_d;
    logic        fsel_q, fsel_d;
    logic        dsel_q, dsel_d;
    logic [5:0]  fcnt_q, fcnt_d;
    logic [5:0]  dcnt_q, dcnt_d;
    logic [11:0] blocks_q, blocks_d;
    logic        frame_acc_q, frame_acc_d;
    logic [5:0]  bcol_q, bcol_d;
    logic [4:0]  brow_q, brow_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        bw_q, bw_d;
    logic        done_q, done_d;

    logic [15:0] bank_q [2][64];
    logic        handshake;
    logic [5:0]  fidx;
    logic [7:0]  row;
    logic [17:0] row_y, row_uv, col, wr_addr;
    logic        last_col;

`ifdef ZIGZAG_SCAN_EN
    // Zigzag position k -> raster index within the 8x8 block.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    assign fidx = ZIGZAG[fcnt_q];
`else
    assign fidx = fcnt_q;
`endif

    assign coeff_ready = running_q && !full_q[fsel_q] && !frame_acc_q;
    assign handshake   = coeff_valid && coeff_ready;

    // Row offsets by shift/add: 320 = 256 + 64, 160 = 128 + 32.
    always_comb begin
        row    = {brow_q, 3'b000} + {5'd0, dcnt_q[5:3]};
        row_y  = ({10'd0, row} << 8) + ({10'd0, row} << 6);
        row_uv = ({10'd0, row} << 7) + ({10'd0, row} << 5);
        col    = {9'd0, bcol_q, dcnt_q[2:0]};
        unique case (plane_q)
            PlaneY:  wr_addr = PRE_IDCT_BASE + row_y + col;
            PlaneU:  wr_addr = U_BASE + row_uv + col;
            default: wr_addr = V_BASE + row_uv + col;
        endcase
        last_col = (plane_q == PlaneY) ? (bcol_q == 6'(Y_BLOCKS_X - 1))
                                       : (bcol_q == 6'(UV_BLOCKS_X - 1));
    end

    always_comb begin
        state_d     = state_q;
        plane_d     = plane_q;
        running_d   = running_q;
        full_d      = full_q;
        fsel_d      = fsel_q;
        dsel_d      = dsel_q;
        fcnt_d      = fcnt_q;
        dcnt_d      = dcnt_q;
        blocks_d    = blocks_q;
        frame_acc_d = frame_acc_q;
        bcol_d      = bcol_q;
        brow_d      = brow_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_n_d      = 1'b1;
        bw_d        = 1'b0;
        done_d      = done_q;

        // Fill side. It only sets full[fsel] when that bank is empty, so it
        // never touches the bit the drain clears (drain only clears full banks).
        if (handshake) begin
            fcnt_d = fcnt_q + 6'd1;
            if (fcnt_q == 6'd63) begin
                full_d[fsel_q] = 1'b1;
                fsel_d         = ~fsel_q;
                blocks_d       = blocks_q + 12'd1;
                if (blocks_q == 12'(TOTAL_BLOCKS - 1)) begin
                    frame_acc_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (Enable) begin
                    running_d   = 1'b1;
                    full_d      = 2'b00;
                    fsel_d      = 1'b0;
                    dsel_d      = 1'b0;
                    fcnt_d      = 6'd0;
                    dcnt_d      = 6'd0;
                    blocks_d    = 12'd0;
                    frame_acc_d = 1'b0;
                    bcol_d      = 6'd0;
                    brow_d      = 5'd0;
                    plane_d     = PlaneY;
                    done_d      = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (full_q[dsel_q]) begin
                    dcnt_d  = 6'd0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                we_n_d  = 1'b0;
                addr_d  = wr_addr;
                wdata_d = bank_q[dsel_q][dcnt_q];
                dcnt_d  = dcnt_q + 6'd1;
                if (dcnt_q == 6'd63) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                bw_d           = 1'b1;
                full_d[dsel_q] = 1'b0;
                dsel_d         = ~dsel_q;
                state_d        = StWait;
                if (!last_col) begin
                    bcol_d = bcol_q + 6'd1;
                end else begin
                    bcol_d = 6'd0;
                    if (brow_q != 5'(BLOCKS_Y - 1)) begin
                        brow_d = brow_q + 5'd1;
                    end else begin
                        brow_d = 5'd0;
                        unique case (plane_q)
                            PlaneY:  plane_d = PlaneU;
                            PlaneU:  plane_d = PlaneV;
                            default: state_d = StDone;
                        endcase
                    end
                end
            end
            StDone: begin
                done_d    = 1'b1;
                running_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= StIdle;
            plane_q     <= PlaneY;
            running_q   <= 1'b0;
            full_q      <= 2'b00;
            fsel_q      <= 1'b0;
            dsel_q      <= 1'b0;
            fcnt_q      <= 6'd0;
            dcnt_q      <= 6'd0;
            blocks_q    <= 12'd0;
            frame_acc_q <= 1'b0;
            bcol_q      <= 6'd0;
            brow_q      <= 5'd0;
            addr_q      <= 18'd0;
            wdata_q     <= 16'd0;
            we_n_q      <= 1'b1;
            bw_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            plane_q     <= plane_d;
            running_q   <= running_d;
            full_q      <= full_d;
            fsel_q      <= fsel_d;
            dsel_q      <= dsel_d;
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            blocks_q    <= blocks_d;
            frame_acc_q <= frame_acc_d;
            bcol_q      <= bcol_d;
            brow_q      <= brow_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            bw_q        <= bw_d;
            done_q      <= done_d;
        end
    end

    // Buffer storage needs no reset: full flags gate every read.
    always_ff @(posedge Clock) begin
        if (handshake) begin
            bank_q[fsel_q][fidx] <= coeff_data;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign block_written   = bw_q;
    assign done            = done_q;

endmodule

// File: tb/tb_idct_coeff_block_writer.sv
// -----------------------------------------------------------------------------
// tb_idct_coeff_block_writer
//
// Directed bench for idct_coeff_block_writer. The DUT runs with BLOCKS_Y = 2
// (80 Y, 40 U, 40 V blocks) so a whole frame fits in a short run; the Y/U/V
// segment bases then follow from the geometry (U at 81920, V at 84480).
// Define ZIGZAG_SCAN_EN for both files to exercise the zigzag build.
// -----------------------------------------------------------------------------
module tb_idct_coeff_block_writer;

    localparam int unsigned BlocksY     = 2;
    localparam int          YBlocks     = 40 * BlocksY;
    localparam int          UvBlocks    = 20 * BlocksY;
    localparam int          TotalBlocks = YBlocks + 2 * UvBlocks;
    localparam int          FrameWords  = TotalBlocks * 64;
    localparam int          UBase       = 76800 + YBlocks * 64;
    localparam int          VBase       = UBase + UvBlocks * 64;
    localparam int          LogDepth    = 16384;

`ifdef ZIGZAG_SCAN_EN
    localparam int ZZ [64] = '{
        0,  1,  8,  16, 9,  2,  3,  10, 17, 24, 32, 25, 18, 11, 4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6,  7,  14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    localparam int ExpData2 = 5;
    localparam int ExpData8 = 2;
`else
    localparam int ExpData2 = 2;
    localparam int ExpData8 = 8;
`endif

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Enable = 1'b0;
    logic        coeff_valid = 1'b0;
    logic [15:0] coeff_data = 16'd0;
    logic        coeff_ready;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        block_written;
    logic        done;

    idct_coeff_block_writer #(
        .BLOCKS_Y(BlocksY)
    ) u_dut (
        .Clock          (Clock),
        .Resetn         (Resetn),
        .Enable         (Enable),
        .coeff_valid    (coeff_valid),
        .coeff_data     (coeff_data),
        .coeff_ready    (coeff_ready),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .block_written  (block_written),
        .done           (done)
    );

    always #5 Clock = ~Clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Write log and event counters, sampled on the falling edge.
    logic [17:0] wa [LogDepth];
    logic [15:0] wd [LogDepth];
    int          wcount = 0;
    int          bw_cnt = 0;
    int          bw_at_blk1 = -1;
    int          sent = 0;
    int          max_backlog = 0;
    bit          ready_low_seen = 1'b0;
    bit          track = 1'b0;
    bit          stop_send = 1'b0;

    always @(negedge Clock) begin
        if (Resetn && !SRAM_we_n && wcount < LogDepth) begin
            if (wcount == 64) bw_at_blk1 = bw_cnt;
            wa[wcount] = SRAM_address;
            wd[wcount] = SRAM_write_data;
            wcount++;
        end
        if (Resetn && block_written) bw_cnt++;
        if (track) begin
            if (coeff_valid && !coeff_ready) ready_low_seen = 1'b1;
            if (sent / 64 - bw_cnt > max_backlog) max_backlog = sent / 64 - bw_cnt;
        end
    end

    // Streams n coefficients base, base+1, ... with valid held high.
    task automatic send_coeffs(input int n, input int base);
        int  cnt = 0;
        int  guard = 0;
        bit  hs;
        while (cnt < n && !stop_send && guard < 40000) begin
            @(negedge Clock);
            if (stop_send) break;
            coeff_valid = 1'b1;
            coeff_data  = 16'(base + cnt);
            hs          = coeff_ready;
            @(posedge Clock);
            if (hs) begin
                cnt++;
                sent++;
            end
            guard++;
        end
        @(negedge Clock);
        coeff_valid = 1'b0;
        if (!stop_send) check_val("send_complete", cnt, n);
    endtask

    task automatic pulse_enable();
        @(negedge Clock);
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
    endtask

    function automatic int exp_addr(input int w);
        int b = w / 64;
        int d = w % 64;
        int base, bx, stride, lb;
        if (b < YBlocks) begin
            base = 76800; bx = 40; stride = 320; lb = b;
        end else if (b < YBlocks + UvBlocks) begin
            base = UBase; bx = 20; stride = 160; lb = b - YBlocks;
        end else begin
            base = VBase; bx = 20; stride = 160; lb = b - YBlocks - UvBlocks;
        end
        return base + ((lb / bx) * 8 + d / 8) * stride + (lb % bx) * 8 + d % 8;
    endfunction

    function automatic int exp_data(input int w);
`ifdef ZIGZAG_SCAN_EN
        int kk = 0;
        for (int k = 0; k < 64; k++) if (ZZ[k] == w % 64) kk = k;
        return (w / 64) * 64 + kk;
`else
        return w;
`endif
    endfunction

    bit seen [262144];

    initial begin
        int g;
        int bad_addr = 0;
        int bad_data = 0;
        int dup = 0;
        int start_w;

        // Reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            Enable      = 1'($urandom_range(0, 1));
            coeff_valid = 1'($urandom_range(0, 1));
            coeff_data  = 16'($urandom);
        end
        check_val("rst_we_n", SRAM_we_n, 1);
        check_val("rst_addr", SRAM_address, 0);
        check_val("rst_wdata", SRAM_write_data, 0);
        check_val("rst_ready", coeff_ready, 0);
        check_val("rst_bw", block_written, 0);
        check_val("rst_done", done, 0);
        @(negedge Clock);
        Enable = 1'b0;
        coeff_valid = 1'b0;
        Resetn = 1'b1;

        // Full frame, raster data = coefficient index.
        pulse_enable();
        check_val("ready_after_enable", coeff_ready, 1);
        track = 1'b1;
        send_coeffs(FrameWords, 0);
        g = 0;
        while (done !== 1'b1 && g < 3000) begin
            @(negedge Clock);
            g++;
        end
        track = 1'b0;
        check_val("frame_done", done, 1);
        check_val("frame_writes", wcount, FrameWords);

        check_val("blk0_w0_addr", wa[0], 76800);
        check_val("blk0_w0_data", wd[0], 0);
        check_val("blk0_w2_data", wd[2], ExpData2);
        check_val("blk0_w7_addr", wa[7], 76807);
        check_val("blk0_w8_addr", wa[8], 77120);
        check_val("blk0_w8_data", wd[8], ExpData8);
        check_val("blk0_w63_addr", wa[63], 79047);
        check_val("blk0_w63_data", wd[63], 63);
        check_val("blk0_bw_once", bw_at_blk1, 1);
        check_val("blk1_start", wa[64], 76808);
        check_val("blk40_start", wa[40 * 64], 79360);
        check_val("first_u_start", wa[YBlocks * 64], UBase);
        check_val("first_u_row1", wa[YBlocks * 64 + 8], UBase + 160);
        check_val("last_addr", wa[FrameWords - 1], VBase + UvBlocks * 64 - 1);

        for (int w = 0; w < wcount && w < FrameWords; w++) begin
            if (int'(wa[w]) != exp_addr(w)) bad_addr++;
            if (int'(wd[w]) != exp_data(w) % 65536) bad_data++;
            if (seen[wa[w]]) dup++;
            seen[wa[w]] = 1'b1;
        end
        check_val("frame_addr_errors", bad_addr, 0);
        check_val("frame_data_errors", bad_data, 0);
        check_val("frame_duplicates", dup, 0);
        check_val("frame_blocks_written", bw_cnt, TotalBlocks);
        check_val("ready_dropped", ready_low_seen, 1);
        check_val("backlog_le_2", max_backlog <= 2, 1);
        repeat (5) @(negedge Clock);
        check_val("done_held", done, 1);
        check_val("ready_idle", coeff_ready, 0);

        // Reset in the middle of the third block.
        pulse_enable();
        check_val("done_cleared", done, 0);
        start_w = wcount;
        fork
            send_coeffs(320, 5000);
        join_none
        g = 0;
        while (wcount < start_w + 2 * 64 + 20 && g < 2000) begin
            @(posedge Clock);
            g++;
        end
        check_val("midblk_reached", wcount >= start_w + 2 * 64 + 20, 1);
        #2;
        stop_send = 1'b1;
        Resetn = 1'b0;
        #1;
        check_val("midrst_we_n", SRAM_we_n, 1);
        check_val("midrst_addr", SRAM_address, 0);
        check_val("midrst_ready", coeff_ready, 0);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        stop_send = 1'b0;
        pulse_enable();
        start_w = wcount;
        send_coeffs(64, 1000);
        g = 0;
        while (wcount < start_w + 64 && g < 500) begin
            @(posedge Clock);
            g++;
        end
        check_val("restart_writes", wcount - start_w, 64);
        check_val("restart_addr", wa[start_w], 76800);
        check_val("restart_data", wd[start_w], 1000);
        check_val("restart_last_addr", wa[start_w + 63], 79047);
        check_val("restart_last_data", wd[start_w + 63], 1063);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
